matrix_ctrl: RTL and testbench
==============================

Name: matrix_ctrl

Overview:
Sequencer for a ROW x COL matrix buffer of WIDTH-bit elements held in an external single-port-write / single-port-read memory.
- Load phase: accepts N = ROW*COL elements over a valid/ready stream and writes them to addresses 0..N-1 in row-major order.
- Read phase: streams the stored matrix out, either row-major or transposed (column-major), over a valid/ready stream.
- Sits between the upstream data source, the matrix storage and the downstream compute consumer.

Parameters:
- ROW, 5, number of matrix rows (>=1).
- COL, 4, number of matrix columns (>=1).
- WIDTH, 16, element width in bits.
- AW, $clog2(ROW*COL), memory address width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_wr  in  1  pulse: begin load phase.
- start_rd  in  1  pulse: begin read phase.
- transpose  in  1  sampled on accepted start_rd; 1 = column-major readout.
- in_valid  in  1  input element valid.
- in_ready  out  1  controller accepts input element.
- in_data  in  WIDTH  input element.
- mem_we  out  1  memory write strobe.
- mem_waddr  out  AW  memory write address.
- mem_wdata  out  WIDTH  memory write data.
- mem_re  out  1  memory read strobe; data returns on mem_rdata exactly 1 cycle later.
- mem_raddr  out  AW  memory read address.
- mem_rdata  in  WIDTH  memory read data.
- out_valid  out  1  output element valid.
- out_ready  in  1  consumer accepts output element.
- out_data  out  WIDTH  output element.
- busy  out  1  high whenever state != IDLE.
- loaded  out  1  a complete matrix has been written since reset.
- done  out  1  one-cycle pulse on the final in or out handshake of a phase.
- err  out  1  one-cycle pulse when start_rd is received while loaded == 0.

Behaviour:
- Reset (async assert, sync release): state = IDLE, counters = 0, loaded = 0, output FIFO empty. in_ready, mem_we, mem_re, out_valid, done, err, busy and all addresses/data outputs are 0.
- States: IDLE, LOAD, READ, FLUSH.
- IDLE:
  - start_wr -> LOAD, write index = 0, loaded cleared.
  - Else start_rd with loaded = 1 -> READ; transpose latched; row and column counters r = c = 0.
  - start_rd with loaded = 0 -> err pulse, remain IDLE.
  - start_wr and start_rd in the same cycle: write wins and start_rd is dropped (no err).
  - Starts arriving outside IDLE are ignored.
- LOAD:
  - in_ready = 1.
  - On in_valid && in_ready (same cycle, combinational): mem_we = 1, mem_waddr = index, mem_wdata = in_data; index increments.
  - Handshake on index N-1: done pulses, loaded = 1, state -> IDLE in the next cycle, and in_ready drops in that next cycle.
  - Throughput is 1 element/cycle.
- READ:
  - Address = r*COL + c, computed with no multiplier in the critical path: an incrementally maintained row base is acceptable.
  - Row-major: c is the inner counter (wraps at COL-1 and increments r).
  - Transpose: r is the inner counter (wraps at ROW-1 and increments c).
  - mem_re asserts when (FIFO occupancy + reads in flight) < 2 and not all N reads have been issued.
  - Read data is written into a 2-entry output FIFO; out_valid = FIFO not empty; out_data = FIFO head.
  - Sustains 1 element/cycle while out_ready is held high; first out_valid appears 2 cycles after start_rd.
  - After the last read is issued -> FLUSH.
- FLUSH:
  - Drains the FIFO. done pulses on the handshake of the N-th output element; state -> IDLE.
- Back-pressure: out_valid and out_data hold stable while out_ready is low. No element is ever lost or duplicated.
- Reset mid-operation: everything returns to reset values immediately; loaded = 0.
- Degenerate case ROW = COL = 1: both phases complete after one handshake.

Optional Feature:
- Macro: MATRIX_CTRL_PERF_EN.
- When defined: adds output stall_cnt [15:0]. It is cleared on accepted start_rd and increments (saturating at 16'hFFFF) on each cycle with out_valid && !out_ready.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package matrix_pkg: state encoding constants (IDLE = 2'd0, LOAD = 2'd1, READ = 2'd2, FLUSH = 2'd3) and the address-width computation for ROW*COL.
- Sub-module matrix_addr_gen: r/c counters, transpose ordering, address output, last-address flag. Interface is advance/clear inputs and addr/last outputs.
- The FIFO stays inline.

Test Plan:
- Load + row-major read, ROW = 5, COL = 4: write 0..19 with in_valid held high -> mem_waddr 0..19 in 20 consecutive cycles, done pulse on element 19. Read with out_ready held high -> out_data 0,1,...,19 back-to-back, done on the 20th output.
- Transpose read of the same matrix -> out_data sequence 0,4,8,12,16,1,5,...,19.
- Back-pressure: toggle out_ready randomly at 50% -> 20 outputs in correct order, out_data stable while stalled. With PERF_EN, stall_cnt equals the number of stalled cycles.
- start_rd after reset, before any load -> err pulse, busy stays 0, no mem_re.
- start_wr and start_rd asserted together in IDLE -> LOAD entered, no err. start_rd during LOAD -> ignored.
- Assert rst_n low after 7 of 20 input elements -> all outputs 0 within the same cycle, loaded = 0, subsequent start_rd gives err.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix buffer sequencer.
// No logic; state encoding and address-width computation only.
// Imported by matrix_ctrl and matrix_addr_gen.
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READ  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Address width for n elements; never below 1 so a 1x1 matrix still has a port.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_ctrl_if.sv
// Input stream, memory port and output stream of the matrix sequencer.
// Pure wiring, no latency.
// Both streams are valid/ready; the memory port has no backpressure.
interface matrix_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_re;
    logic [AW-1:0]    mem_raddr;
    logic [WIDTH-1:0] mem_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        input  in_valid, in_data, mem_rdata, out_ready,
        output in_ready, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
               out_valid, out_data
    );

    modport slave (
        output in_valid, in_data, mem_rdata, out_ready,
        input  in_ready, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
               out_valid, out_data
    );
endinterface

// File: rtl/matrix_addr_gen.sv
// Read address walker: row-major or column-major over a ROW x COL matrix.
// addr/last are valid combinationally from the counters; advance steps next cycle.
// No backpressure of its own; the caller only advances when a read is issued.
module matrix_addr_gen
    import matrix_pkg::*;
#(
    parameter int ROW = 5,
    parameter int COL = 4,
    parameter int AW  = addr_w(ROW * COL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    input  logic          transpose,
    output logic [AW-1:0] addr,
    output logic          last
);
    // base_q tracks r*COL incrementally so the address is a single add.
    logic [AW-1:0] r_q, r_d, c_q, c_d, base_q, base_d;

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            c_q    <= '0;
            base_q <= '0;
        end else begin
            r_q    <= r_d;
            c_q    <= c_d;
            base_q <= base_d;
        end
    end

    // Step the inner counter; wrap carries into the outer one.
    always_comb begin
        r_d    = r_q;
        c_d    = c_q;
        base_d = base_q;
        if (clear) begin
            r_d    = '0;
            c_d    = '0;
            base_d = '0;
        end else if (advance) begin
            if (!transpose) begin
                if (c_q == AW'(COL - 1)) begin
                    c_d    = '0;
                    r_d    = r_q + 1'b1;
                    base_d = base_q + AW'(COL);
                end else begin
                    c_d = c_q + 1'b1;
                end
            end else begin
                if (r_q == AW'(ROW - 1)) begin
                    r_d    = '0;
                    base_d = '0;
                    c_d    = c_q + 1'b1;
                end else begin
                    r_d    = r_q + 1'b1;
                    base_d = base_q + AW'(COL);
                end
            end
        end
    end

    // Both orderings end on the bottom-right element.
    always_comb begin
        addr = base_q + c_q;
        last = (r_q == AW'(ROW - 1)) && (c_q == AW'(COL - 1));
    end
endmodule

// File: rtl/matrix_ctrl.sv
// Load/readout sequencer for a ROW x COL matrix in external memory; MATRIX_CTRL_PERF_EN adds stall_cnt.
// Load writes combinationally on the input handshake; readout lands 2 edges after start_rd acceptance.
// in_ready only in LOAD; reads throttle so the 2-entry output FIFO never overflows under out_ready low.
module matrix_ctrl
    import matrix_pkg::*;
#(
    parameter int ROW   = 5,
    parameter int COL   = 4,
    parameter int WIDTH = 16,
    parameter int AW    = addr_w(ROW * COL)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_wr,
    input  logic start_rd,
    input  logic transpose,
    matrix_ctrl_if.master bus,
    output logic busy,
    output logic loaded,
    output logic done,
    output logic err
`ifdef MATRIX_CTRL_PERF_EN
    ,
    output logic [15:0] stall_cnt
`endif
);
    localparam logic [AW-1:0] LAST_IDX = AW'(ROW * COL - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    widx_q, widx_d, ocnt_q, ocnt_d;
    logic             loaded_q, loaded_d, tr_q, tr_d, infl_q, infl_d;
    logic [WIDTH-1:0] f0_q, f0_d, f1_q, f1_d;
    logic             wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]       cnt_q, cnt_d;

    logic             in_hs, pop, push, rd_issue, wr_accept, rd_accept, out_vld;
    logic [2:0]       occ;
    logic [AW-1:0]    ag_addr;
    logic             ag_last;

    matrix_addr_gen #(.ROW(ROW), .COL(COL), .AW(AW)) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (rd_accept),
        .advance   (rd_issue),
        .transpose (tr_q),
        .addr      (ag_addr),
        .last      (ag_last)
    );

    // Handshake and throttle terms shared by the FSM and datapath.
    always_comb begin
        wr_accept = (state_q == IDLE) && start_wr;
        rd_accept = (state_q == IDLE) && start_rd && !start_wr && loaded_q;
        in_hs     = (state_q == LOAD) && bus.in_valid;
        out_vld   = (cnt_q != 2'd0);
        pop       = out_vld && bus.out_ready;
        push      = infl_q;
        // An element leaving this cycle frees its slot in time for a read issued now.
        occ       = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};
        rd_issue  = (state_q == READ) && (occ < 3'd2);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            widx_q   <= '0;
            ocnt_q   <= '0;
            loaded_q <= 1'b0;
            tr_q     <= 1'b0;
            infl_q   <= 1'b0;
            f0_q     <= '0;
            f1_q     <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            widx_q   <= widx_d;
            ocnt_q   <= ocnt_d;
            loaded_q <= loaded_d;
            tr_q     <= tr_d;
            infl_q   <= infl_d;
            f0_q     <= f0_d;
            f1_q     <= f1_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state: start_wr has priority in IDLE; starts elsewhere are ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_wr) state_d = LOAD;
                     else if (start_rd && loaded_q) state_d = READ;
            LOAD:    if (in_hs && (widx_q == LAST_IDX)) state_d = IDLE;
            READ:    if (rd_issue && ag_last) state_d = FLUSH;
            FLUSH:   if (pop && (ocnt_q == LAST_IDX)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters, latched mode and the 2-entry output FIFO.
    always_comb begin
        widx_d   = widx_q;
        ocnt_d   = ocnt_q;
        loaded_d = loaded_q;
        tr_d     = tr_q;
        infl_d   = rd_issue;
        f0_d     = f0_q;
        f1_d     = f1_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        if (wr_accept) begin
            widx_d   = '0;
            loaded_d = 1'b0;
        end else if (in_hs) begin
            widx_d = widx_q + 1'b1;
            if (widx_q == LAST_IDX) loaded_d = 1'b1;
        end
        if (rd_accept) begin
            tr_d   = transpose;
            ocnt_d = '0;
        end else if (pop) begin
            ocnt_d = ocnt_q + 1'b1;
        end
        if (push) begin
            if (wptr_q) f1_d = bus.mem_rdata;
            else        f0_d = bus.mem_rdata;
            wptr_d = !wptr_q;
        end
        if (pop) rptr_d = !rptr_q;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // Outputs; address/data buses are zero whenever their strobe is low.
    always_comb begin
        bus.in_ready  = (state_q == LOAD);
        bus.mem_we    = in_hs;
        bus.mem_waddr = in_hs ? widx_q : '0;
        bus.mem_wdata = in_hs ? bus.in_data : '0;
        bus.mem_re    = rd_issue;
        bus.mem_raddr = rd_issue ? ag_addr : '0;
        bus.out_valid = out_vld;
        bus.out_data  = !out_vld ? '0 : (rptr_q ? f1_q : f0_q);
        busy          = (state_q != IDLE);
        loaded        = loaded_q;
        done          = (in_hs && (widx_q == LAST_IDX))
                     || ((state_q == FLUSH) && pop && (ocnt_q == LAST_IDX));
        err           = (state_q == IDLE) && start_rd && !start_wr && !loaded_q;
    end

`ifdef MATRIX_CTRL_PERF_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of cycles the consumer holds off a valid element.
    always_comb begin
        stall_d = stall_q;
        if (rd_accept) stall_d = '0;
        else if (out_vld && !bus.out_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_matrix_ctrl.sv
// Directed bench for matrix_ctrl at ROW=5, COL=4 with a 1-cycle-latency memory model.
// Drives just after the falling edge, samples 1 ns later.
// Covers reset, err, start priority, load, both readouts, back-pressure and mid-load reset.
module tb_matrix_ctrl;
    localparam int ROW = 5;
    localparam int COL = 4;
    localparam int N   = ROW * COL;
    localparam int W   = 16;
    localparam int AW  = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_wr = 1'b0, start_rd = 1'b0, transpose = 1'b0;
    logic busy, loaded, done, err;
`ifdef MATRIX_CTRL_PERF_EN
    logic [15:0] stall_cnt;
`endif
    int n_chk = 0;
    int n_fail = 0;

    matrix_ctrl_if #(.WIDTH(W), .AW(AW)) bus ();

    matrix_ctrl #(.ROW(ROW), .COL(COL), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_wr  (start_wr),
        .start_rd  (start_rd),
        .transpose (transpose),
        .bus       (bus),
        .busy      (busy),
        .loaded    (loaded),
        .done      (done),
        .err       (err)
`ifdef MATRIX_CTRL_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // External memory: synchronous write, 1-cycle registered read.
    logic [W-1:0] mem_m [0:31];
    always @(posedge clk) begin
        if (bus.mem_we) mem_m[bus.mem_waddr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem_m[bus.mem_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_val(input bit tr, input int k);
        int idx;
        if (tr) idx = (k % ROW) * COL + (k / ROW);
        else    idx = k;
        return 16'hA000 + W'(idx);
    endfunction

    task automatic run_read(input bit tr, input bit rnd);
        int k = 0, cyc = 1, stall = 0, first = 0, last = 0;
        logic pv = 1'b0, pr = 1'b1;
        logic [W-1:0] pd = '0;
        @(negedge clk);
        start_rd = 1'b1; transpose = tr; bus.out_ready = 1'b1;
        #1 chk("rd_start_err", err, 1'b0);
        @(negedge clk);
        start_rd = 1'b0; transpose = 1'b0;
        while (k < N && cyc < 400) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (cyc == 1) begin
                chk("rd_first_re", bus.mem_re, 1'b1);
                chk("rd_first_addr", bus.mem_raddr, '0);
            end
            if (cyc == 2) chk("rd_valid_early", bus.out_valid, 1'b0);
            if (cyc == 3) chk("rd_valid_lat", bus.out_valid, 1'b1);
            if (pv && !pr) begin
                chk("stall_valid", bus.out_valid, 1'b1);
                chk("stall_data", bus.out_data, pd);
            end
            if (bus.out_valid && !bus.out_ready) stall++;
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("rd_data%0d_%0d", tr, k), bus.out_data, exp_val(tr, k));
                chk("rd_done", done, (k == N - 1));
                if (k == 0) first = cyc;
                last = cyc;
                k++;
            end else begin
                chk("rd_done_idle", done, 1'b0);
            end
            pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data;
            @(negedge clk);
            cyc++;
        end
        bus.out_ready = 1'b1;
        #1;
        chk("rd_count", k, N);
        if (!rnd) chk("rd_b2b", last - first, N - 1);
        chk("rd_busy_end", busy, 1'b0);
        chk("rd_valid_end", bus.out_valid, 1'b0);
`ifdef MATRIX_CTRL_PERF_EN
        chk("stall_cnt", stall_cnt, stall);
`endif
    endtask

    initial begin
        logic any_re, any_busy, any_err;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        #3;
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_re", bus.mem_re, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_addrs", {bus.mem_waddr, bus.mem_raddr}, '0);
        chk("rst_flags", {busy, loaded, done, err}, 4'b0000);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Read before any load: err, nothing starts.
        @(negedge clk);
        start_rd = 1'b1;
        #1 chk("early_err", err, 1'b1);
        chk("early_busy", busy, 1'b0);
        any_re = 1'b0; any_busy = 1'b0; any_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start_rd = 1'b0;
            #1;
            any_re |= bus.mem_re; any_busy |= busy; any_err |= err;
        end
        chk("early_no_re", any_re, 1'b0);
        chk("early_no_busy", any_busy, 1'b0);
        chk("early_err_pulse", any_err, 1'b0);

        // Simultaneous starts: write wins, no err. start_rd during LOAD is ignored.
        @(negedge clk);
        start_wr = 1'b1; start_rd = 1'b1;
        #1 chk("both_err", err, 1'b0);
        @(negedge clk);
        start_wr = 1'b0;
        #1 chk("both_busy", busy, 1'b1);
        chk("both_in_ready", bus.in_ready, 1'b1);
        chk("load_rd_err", err, 1'b0);
        for (int i = 0; i < N; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1) start_rd = 1'b0;
            bus.in_valid = 1'b1; bus.in_data = 16'hA000 + W'(i);
            #1;
            chk("ld_we", bus.mem_we, 1'b1);
            chk($sformatf("ld_waddr%0d", i), bus.mem_waddr, i);
            chk("ld_wdata", bus.mem_wdata, 16'hA000 + i);
            chk("ld_done", done, (i == N - 1));
        end
        @(negedge clk);
        #1;
        chk("ld_in_ready_end", bus.in_ready, 1'b0);
        chk("ld_loaded", loaded, 1'b1);
        chk("ld_busy_end", busy, 1'b0);
        chk("ld_no_we", bus.mem_we, 1'b0);
        bus.in_valid = 1'b0;

        run_read(1'b0, 1'b0);
        run_read(1'b1, 1'b0);
        run_read(1'b0, 1'b1);
        run_read(1'b1, 1'b1);

        // Reset after 7 of 20 elements of a fresh load.
        @(negedge clk);
        start_wr = 1'b1;
        @(negedge clk);
        start_wr = 1'b0;
        #1 chk("reload_clears_loaded", loaded, 1'b0);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            bus.in_valid = 1'b1; bus.in_data = 16'h5000 + W'(i);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", bus.in_ready, 1'b0);
        chk("mrst_mem_we", bus.mem_we, 1'b0);
        chk("mrst_waddr", bus.mem_waddr, '0);
        chk("mrst_flags", {busy, loaded, done, err, bus.out_valid}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1; bus.in_valid = 1'b0;
        @(negedge clk);
        start_rd = 1'b1;
        #1 chk("mrst_err", err, 1'b1);
        @(negedge clk);
        start_rd = 1'b0;
        #1 chk("mrst_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
